// File: rtl/mod_signal_gen.sv
// CW/AM/FM DDS modulator driving the offset-binary DAC path for receive-chain loopback.
// Optional: `define MOD_GEN_PHASE_SYNC_EN adds phase_sync to restart both phases at a sample.
module mod_signal_gen #(
    parameter int PHASE_W = 32,
    parameter int LUT_AW  = 10,
    parameter int DATA_W  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_en,
`ifdef MOD_GEN_PHASE_SYNC_EN
    input  logic               phase_sync,
`endif
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [2:0]         cfg_type,
    input  logic [PHASE_W-1:0] cfg_carrier_fw,
    input  logic [PHASE_W-1:0] cfg_mod_fw,
    input  logic [7:0]         cfg_ma,
    input  logic [23:0]        cfg_dev_fw,
    output logic [DATA_W-1:0]  da_data,
    output logic               da_valid,
    output logic               overrun
);
    localparam int     QN     = 2 ** (LUT_AW - 2);
    localparam int     SH     = 9;
    localparam int     ENV_W  = 11;
    localparam int     AM_W   = 9 + DATA_W;
    localparam int     Y_W    = DATA_W + ENV_W;
    localparam int     DEV_W  = 25 + DATA_W;
    localparam longint PI_Q30 = 64'sd3373259426;
    localparam longint AMP    = longint'(2 ** (DATA_W - 1) - 1);

    typedef struct packed {
        logic [2:0]         mode;
        logic [PHASE_W-1:0] carrier_fw;
        logic [PHASE_W-1:0] mod_fw;
        logic [7:0]         ma;
        logic [23:0]        dev_fw;
    } cfg_t;

    typedef enum logic [2:0] {READY, S1, S2, S3, S4} state_t;

    // Elaboration-time quarter-wave table: round(AMP*sin(pi*k/2^(LUT_AW-1))), Taylor in Q30.
    function automatic logic signed [DATA_W-1:0] sin_q(input int k);
        longint x, x2, term, acc;
        x    = longint'(k) * PI_Q30 / longint'(2 ** (LUT_AW - 1));
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int n = 1; n < 10; n++) begin
            term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
            acc  = acc + term;
        end
        return DATA_W'((acc * AMP + (longint'(1) <<< 29)) >>> 30);
    endfunction

    logic signed [DATA_W-1:0] sin_rom [0:QN];
    for (genvar g = 0; g <= QN; g++) begin : g_rom
        localparam logic signed [DATA_W-1:0] V = sin_q(g);
        assign sin_rom[g] = V;
    end

    state_t                   state_q, state_d;
    cfg_t                     cfg_in, sh, act, sel;
    logic                     pending, accept, take, sync, sel_idle, act_idle, act_am, act_fm;
    logic [PHASE_W-1:0]       carrier_ph, mod_ph, p_c, m_use, dev_term;
    logic [LUT_AW-1:0]        p_mk;
    logic signed [DATA_W-1:0] c_q, m_q, y;
    logic [ENV_W-1:0]         env_q, env_n;
    logic signed [AM_W-1:0]   am_prod;
    logic signed [Y_W-1:0]    y_prod;
    logic signed [DEV_W-1:0]  dev_prod;
    logic [1:0][LUT_AW-1:0]   lut_k;
    logic [1:0][LUT_AW-2:0]   lut_a;
    logic [1:0][DATA_W-1:0]   lut_q;

`ifdef MOD_GEN_PHASE_SYNC_EN
    assign sync = phase_sync;
`else
    assign sync = 1'b0;
`endif

    assign cfg_in    = {cfg_type, cfg_carrier_fw, cfg_mod_fw, cfg_ma, cfg_dev_fw};
    assign cfg_ready = !pending;
    assign accept    = cfg_valid && cfg_ready;
    assign take      = sample_en && (state_q == READY);

    // A config accepted in the same cycle as a taken strobe goes straight to this sample.
    assign sel      = accept ? cfg_in : (pending ? sh : act);
    assign sel_idle = !(sel.mode inside {3'b001, 3'b010, 3'b100});
    assign act_idle = !(act.mode inside {3'b001, 3'b010, 3'b100});
    assign act_am   = (act.mode == 3'b010);
    assign act_fm   = (act.mode == 3'b100);
    assign m_use    = (sel_idle || sync) ? '0 : mod_ph;

    always_comb begin
        lut_a = '0;
        lut_q = '0;
        lut_k = {p_mk, p_c[PHASE_W-1 -: LUT_AW]};
        for (int i = 0; i < 2; i++) begin
            lut_a[i] = lut_k[i][LUT_AW-2] ? (LUT_AW-1)'(QN - int'(lut_k[i][LUT_AW-3:0]))
                                          : {1'b0, lut_k[i][LUT_AW-3:0]};
            lut_q[i] = lut_k[i][LUT_AW-1] ? -sin_rom[lut_a[i]] : sin_rom[lut_a[i]];
        end
    end

    assign am_prod  = $signed({{(AM_W-8){1'b0}}, act.ma}) * $signed({{(AM_W-DATA_W){m_q[DATA_W-1]}}, m_q});
    assign env_n    = act_am ? ENV_W'(am_prod >>> SH) + ENV_W'(256) : ENV_W'(256);
    assign dev_prod = $signed({{(DEV_W-24){1'b0}}, act.dev_fw}) * $signed({{(DEV_W-DATA_W){m_q[DATA_W-1]}}, m_q});
    assign dev_term = PHASE_W'(dev_prod >>> SH);
    assign y_prod   = $signed({{(Y_W-DATA_W){c_q[DATA_W-1]}}, c_q}) * $signed({{(Y_W-ENV_W){env_q[ENV_W-1]}}, env_q});
    assign y        = DATA_W'(y_prod >>> SH);

    always_ff @(posedge clk) begin
        if (rst) state_q <= READY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        da_valid = 1'b0;
        case (state_q)
            READY:   if (sample_en) state_d = S1;
            S1:      state_d = S2;
            S2:      state_d = S3;
            S3:      state_d = S4;
            S4: begin
                da_valid = 1'b1;
                state_d  = READY;
            end
            default: state_d = READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= 1'b0;
            sh         <= '0;
            act        <= '0;
            carrier_ph <= '0;
            mod_ph     <= '0;
            p_c        <= '0;
            p_mk       <= '0;
            c_q        <= '0;
            m_q        <= '0;
            env_q      <= '0;
            da_data    <= {1'b1, {(DATA_W-1){1'b0}}};
            overrun    <= 1'b0;
        end else begin
            if (accept) sh <= cfg_in;
            if (take)        pending <= 1'b0;
            else if (accept) pending <= 1'b1;
            if (sample_en && state_q != READY) overrun <= 1'b1;
            if (take) begin
                act    <= sel;
                p_c    <= (sel_idle || sync) ? '0 : carrier_ph;
                p_mk   <= m_use[PHASE_W-1 -: LUT_AW];
                mod_ph <= sel_idle ? '0 : m_use + sel.mod_fw;
                if (sel_idle) carrier_ph <= '0;
            end
            if (state_q == S1) begin
                c_q <= lut_q[0];
                m_q <= lut_q[1];
            end
            // Carrier advances once the modulating sample is known (needed for FM).
            if (state_q == S2) begin
                env_q      <= env_n;
                carrier_ph <= act_idle ? '0 : p_c + act.carrier_fw + (act_fm ? dev_term : '0);
            end
            if (state_q == S3) da_data <= {~y[DATA_W-1], y[DATA_W-2:0]};
        end
    end
endmodule
